branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-side counterpart to the EX-stage branch comparator.
- Predicts taken/target for the PC being fetched in IF. Prediction is combinational from a direct-mapped BTB with 2-bit saturating counters.
- Is updated with the resolved outcome (pc_sel, computed target) from EX.
- Raises a mispredict flush/redirect for the hazard unit and keeps branch/mispredict performance counters.

Parameters:
- IDX_W, 4: BTB index width; entries = 2**IDX_W, indexed by pc[IDX_W+1:2].
- TAG_W, 26: tag width = 32-IDX_W-2 (pc[31:IDX_W+2]). Fixed relation, not independently settable.

Ports:
- i_clk  in  1  core clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_if_pc  in  32  PC of the instruction being fetched
- o_pred_taken  out  1  1 = fetch next from o_pred_target
- o_pred_target  out  32  predicted target (valid when o_pred_taken=1)
- i_upd_valid  in  1  EX holds a resolved branch/jump this cycle (not bubble, not flushed)
- i_upd_pc  in  32  PC of the resolved instruction
- i_upd_is_jump  in  1  JAL/JALR (unconditional)
- i_upd_taken  in  1  actual outcome (pc_sel from comparator)
- i_upd_target  in  32  actual computed target
- i_upd_pred_taken  in  1  prediction carried down the pipeline for this instruction
- i_upd_pred_target  in  32  predicted target carried down the pipeline
- o_mispredict  out  1  flush IF/ID and redirect
- o_redirect_pc  out  32  correct next PC when o_mispredict=1
- o_br_count  out  32  resolved branches+jumps
- o_mp_count  out  32  mispredicts

Behaviour:
- Reset (async, i_reset=0):
  - All valid bits = 0; all counters = 2'b01 (weakly not-taken); tags/targets = 0.
  - o_br_count = 0, o_mp_count = 0.
  - Comb outputs follow from cleared state: o_pred_taken = 0, o_pred_target = 0.
  - Reset asserted mid-operation clears state immediately.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx] == i_if_pc[31:IDX_W+2]).
  - o_pred_taken = hit & ctr[idx][1].
  - o_pred_target = hit ? target[idx] : 0.
- Update (rising edge, only when i_upd_valid=1 and i_reset=1):
  - Jump, hit or miss: write entry with valid=1, tag, target=i_upd_target, ctr=2'b11.
  - Branch taken, miss: allocate (overwrite any victim), target=i_upd_target, ctr=2'b10.
  - Branch taken, hit: target=i_upd_target, ctr=sat_inc(ctr) (11 stays 11).
  - Branch not taken, hit: ctr=sat_dec(ctr) (00 stays 00); target and valid unchanged.
  - Branch not taken, miss: no write.
- Read/write collision: update and lookup to the same index in one cycle → lookup returns pre-update contents; new contents are visible the next cycle. No bypass.
- Mispredict (combinational from update inputs):
  - o_mispredict = i_upd_valid & ((i_upd_pred_taken != i_upd_taken) | (i_upd_taken & i_upd_pred_taken & (i_upd_pred_target != i_upd_target))).
  - o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 4 (32-bit, wraps).
- Counters:
  - o_br_count increments on every i_upd_valid.
  - o_mp_count increments when o_mispredict=1.
  - Both wrap from 0xFFFFFFFF to 0 silently.
- i_upd_valid=0: no state change, o_mispredict=0.

Decomposition:
- Shared package (existing core pkg):
  - Counter encoding constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Opcode constants OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111, used by the EX decode that drives i_upd_is_jump.
- One sub-module: sat_counter2, a pure combinational next-state function (inc/dec/set) instantiated in the update path. The table stays in the top module.

Test Plan:
- Reset then lookup i_if_pc=0x100 → o_pred_taken=0, o_pred_target=0; both perf counters = 0.
- Taken branch, cold BTB:
  - Update pc=0x100, taken=1, target=0x80, pred_taken=0 → o_mispredict=1, o_redirect_pc=0x80.
  - Next cycle, lookup 0x100 → taken=1, target=0x80 (ctr=10).
- Decrement from WT: from ctr=10, not-taken update at 0x100 with pred_taken=1 → o_mispredict=1, o_redirect_pc=0x104. Then lookup gives taken=0 (ctr=01). A second not-taken update gives ctr=00, and a further one stays 00.
- Aliasing: 0x100 and 0x500 share an index (IDX_W=4). A jump at 0x500 to target 0x40 evicts 0x100 → lookup 0x100 misses (taken=0); lookup 0x500 gives taken=1, target=0x40.
- JALR target change: entry holds 0x200→0x300; update target=0x340 with pred_target=0x300 → o_mispredict=1, redirect=0x340; the entry target becomes 0x340.
- Same-cycle lookup and update on 0x100 (cold BTB) → lookup shows taken=0 that cycle and taken=1 the next. Assert i_reset low mid-run → all entries invalid and counters 0 immediately.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared core definitions used by the fetch predictor and EX decode.
// Counter encodings and control-flow opcodes.
package branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter next-state function.
// set has priority, then inc, then dec; otherwise the count holds.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       set_i,
    input  logic [1:0] set_val_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (set_i) begin
            ctr_o = set_val_i;
        end else if (inc_i) begin
            if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
        end else if (dec_i) begin
            if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters,
// EX-stage update, mispredict redirect and performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_is_jump,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    input  logic [31:0] i_upd_pred_target,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mp_count
);

    localparam int TAG_W = 32 - IDX_W - 2;
    localparam int NENT  = 1 << IDX_W;

    logic [NENT-1:0]  valid_q;
    logic [1:0]       ctr_q [NENT];
    logic [TAG_W-1:0] tag_q [NENT];
    logic [31:0]      tgt_q [NENT];
    logic [31:0]      br_cnt_q, br_cnt_d;
    logic [31:0]      mp_cnt_q, mp_cnt_d;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_we;
    logic             upd_wr_tgt;
    logic             ctr_set;
    logic             ctr_inc;
    logic             ctr_dec;
    logic [1:0]       ctr_set_val;
    logic [1:0]       ctr_nxt;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{i_if_pc[1:0], i_upd_pc[1:0]};

    assign if_idx = i_if_pc[IDX_W+1:2];
    assign if_tag = i_if_pc[31:IDX_W+2];
    assign if_hit = valid_q[if_idx] & (tag_q[if_idx] == if_tag);

    assign o_pred_taken  = if_hit & ctr_q[if_idx][1];
    assign o_pred_target = if_hit ? tgt_q[if_idx] : 32'd0;

    assign upd_idx = i_upd_pc[IDX_W+1:2];
    assign upd_tag = i_upd_pc[31:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

    // Not-taken branches that miss never allocate.
    always_comb begin
        upd_we      = 1'b0;
        upd_wr_tgt  = 1'b0;
        ctr_set     = 1'b0;
        ctr_inc     = 1'b0;
        ctr_dec     = 1'b0;
        ctr_set_val = WNT;
        if (i_upd_valid) begin
            if (i_upd_is_jump) begin
                upd_we      = 1'b1;
                upd_wr_tgt  = 1'b1;
                ctr_set     = 1'b1;
                ctr_set_val = ST;
            end else if (i_upd_taken) begin
                upd_we     = 1'b1;
                upd_wr_tgt = 1'b1;
                ctr_inc    = upd_hit;
                ctr_set    = ~upd_hit;
                ctr_set_val = WT;
            end else if (upd_hit) begin
                upd_we  = 1'b1;
                ctr_dec = 1'b1;
            end
        end
    end

    sat_counter2 u_ctr (
        .ctr_i     (ctr_q[upd_idx]),
        .inc_i     (ctr_inc),
        .dec_i     (ctr_dec),
        .set_i     (ctr_set),
        .set_val_i (ctr_set_val),
        .ctr_o     (ctr_nxt)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= '0;
            for (int i = 0; i < NENT; i++) begin
                ctr_q[i] <= WNT;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (upd_we) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            ctr_q[upd_idx]   <= ctr_nxt;
            if (upd_wr_tgt) tgt_q[upd_idx] <= i_upd_target;
        end
    end

    assign o_mispredict = i_upd_valid &
        ((i_upd_pred_taken != i_upd_taken) |
         (i_upd_taken & i_upd_pred_taken &
          (i_upd_pred_target != i_upd_target)));

    assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (i_upd_valid)  br_cnt_d = br_cnt_q + 32'd1;
        if (o_mispredict) mp_cnt_d = mp_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign o_br_count = br_cnt_q;
    assign o_mp_count = mp_cnt_q;

endmodule
